// File: rtl/musa_pkg.sv
// Shared constants for the MUSA instruction-fetch stage.
package musa_pkg;

    localparam int PC_W      = 32;
    localparam int RAS_DEPTH = 8;

endpackage

// File: rtl/return_stack.sv
// Return-address stack: configurable width/depth, reject or circular overflow,
// replace-top on simultaneous push+pop, sticky error flags and a combinational top.
module return_stack
    import musa_pkg::*;
#(
    parameter int DATA_W = PC_W,
    parameter int DEPTH  = RAS_DEPTH,
    parameter bit WRAP   = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       clear_err,
    output logic [DATA_W-1:0]          pop_data,
    output logic                       pop_valid,
    output logic [DATA_W-1:0]          top,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  ptr_m1;
    logic [DATA_W-1:0] rd_data;

    logic do_replace;
    logic do_bypass;
    logic do_push;
    logic do_pop;
    logic ovf_set;
    logic unf_set;

    // DEPTH is a power of two, so plain wrap-around gives the modulo pointer.
    assign ptr_m1  = ptr - PTR_W'(1);
    assign rd_data = mem[ptr_m1];

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign top   = empty ? '0 : rd_data;

    assign do_replace = push & pop & ~empty;
    assign do_bypass  = push & pop & empty;
    assign do_push    = push & ~pop & (~full | WRAP);
    assign do_pop     = pop & ~push & ~empty;
    assign ovf_set    = push & ~pop & full;
    assign unf_set    = pop & ~push & empty;

    // Storage has no reset; a single write port at either ptr or ptr-1.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (do_replace) begin
                mem[ptr_m1] <= push_data;
            end else if (do_push) begin
                mem[ptr] <= push_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= '0;
            count     <= '0;
            pop_data  <= '0;
            pop_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            pop_valid <= do_replace | do_bypass | do_pop;

            if (do_replace || do_pop) begin
                pop_data <= rd_data;
            end else if (do_bypass) begin
                pop_data <= push_data;
            end

            if (do_push) begin
                ptr <= ptr + PTR_W'(1);
                if (!full) begin
                    count <= count + CNT_W'(1);
                end
            end else if (do_pop) begin
                ptr   <= ptr_m1;
                count <= count - CNT_W'(1);
            end

            // A setting event in the same cycle beats clear_err.
            overflow  <= (overflow & ~clear_err) | ovf_set;
            underflow <= (underflow & ~clear_err) | unf_set;
        end
    end

endmodule

// File: tb/tb_return_stack.sv
// Randomized and directed bench for return_stack, run on a reject and a wrap instance side by side.
module tb_return_stack;

    localparam int DW = 32;
    localparam int DP = 8;
    localparam int CW = $clog2(DP + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [DW-1:0] push_data = '0;
    logic          clear_err = 1'b0;

    logic [DW-1:0] pop_data_r, pop_data_w, top_r, top_w;
    logic          pop_valid_r, pop_valid_w, empty_r, empty_w, full_r, full_w;
    logic          overflow_r, overflow_w, underflow_r, underflow_w;
    logic [CW-1:0] count_r, count_w;

    int checks = 0;
    int failures = 0;

    // Reference state: index 0 = reject instance, 1 = wrap instance.
    // st[k][0] is the oldest entry, st[k][sz[k]-1] the top.
    logic [DW-1:0] st [2][DP];
    int            sz [2];
    logic [DW-1:0] m_pd [2];
    bit            m_pv [2];
    bit            m_ovf [2];
    bit            m_unf [2];

    always #5 clk = ~clk;

    return_stack #(.DATA_W(DW), .DEPTH(DP), .WRAP(1'b0)) u_rej (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .push_data(push_data),
        .clear_err(clear_err), .pop_data(pop_data_r), .pop_valid(pop_valid_r),
        .top(top_r), .count(count_r), .empty(empty_r), .full(full_r),
        .overflow(overflow_r), .underflow(underflow_r)
    );

    return_stack #(.DATA_W(DW), .DEPTH(DP), .WRAP(1'b1)) u_wrap (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .push_data(push_data),
        .clear_err(clear_err), .pop_data(pop_data_w), .pop_valid(pop_valid_w),
        .top(top_w), .count(count_w), .empty(empty_w), .full(full_w),
        .overflow(overflow_w), .underflow(underflow_w)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input int k, input bit wrap);
        bit set_o = 0;
        bit set_u = 0;
        if (reset) begin
            sz[k] = 0; m_pd[k] = '0; m_pv[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
            return;
        end
        m_pv[k] = 0;
        if (push && pop) begin
            m_pv[k] = 1;
            if (sz[k] > 0) begin
                m_pd[k] = st[k][sz[k]-1];
                st[k][sz[k]-1] = push_data;
            end else begin
                m_pd[k] = push_data;
            end
        end else if (push) begin
            if (sz[k] < DP) begin
                st[k][sz[k]] = push_data;
                sz[k]++;
            end else begin
                set_o = 1;
                if (wrap) begin
                    for (int i = 0; i < DP - 1; i++) st[k][i] = st[k][i+1];
                    st[k][DP-1] = push_data;
                end
            end
        end else if (pop) begin
            if (sz[k] > 0) begin
                sz[k]--;
                m_pd[k] = st[k][sz[k]];
                m_pv[k] = 1;
            end else begin
                set_u = 1;
            end
        end
        m_ovf[k] = (m_ovf[k] && !clear_err) || set_o;
        m_unf[k] = (m_unf[k] && !clear_err) || set_u;
    endtask

    task automatic compare_all();
        logic [DW-1:0] exp_top [2];
        for (int k = 0; k < 2; k++) exp_top[k] = (sz[k] > 0) ? st[k][sz[k]-1] : '0;
        check("rej.pop_data",  pop_data_r,  m_pd[0]);
        check("rej.pop_valid", pop_valid_r, m_pv[0]);
        check("rej.top",       top_r,       exp_top[0]);
        check("rej.count",     count_r,     sz[0]);
        check("rej.empty",     empty_r,     sz[0] == 0);
        check("rej.full",      full_r,      sz[0] == DP);
        check("rej.overflow",  overflow_r,  m_ovf[0]);
        check("rej.underflow", underflow_r, m_unf[0]);
        check("wrap.pop_data",  pop_data_w,  m_pd[1]);
        check("wrap.pop_valid", pop_valid_w, m_pv[1]);
        check("wrap.top",       top_w,       exp_top[1]);
        check("wrap.count",     count_w,     sz[1]);
        check("wrap.empty",     empty_w,     sz[1] == 0);
        check("wrap.full",      full_w,      sz[1] == DP);
        check("wrap.overflow",  overflow_w,  m_ovf[1]);
        check("wrap.underflow", underflow_w, m_unf[1]);
    endtask

    task automatic cycle(input bit rs, input bit pu, input bit po, input logic [DW-1:0] d, input bit clr);
        reset = rs; push = pu; pop = po; push_data = d; clear_err = clr;
        @(posedge clk);
        model_step(0, 1'b0);
        model_step(1, 1'b1);
        #1;
        compare_all();
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            sz[k] = 0; m_pd[k] = '0; m_pv[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
        end
        #1;
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);

        // Basic LIFO order with back-to-back pops.
        cycle(0, 1, 0, 32'h100, 0);
        cycle(0, 1, 0, 32'h200, 0);
        cycle(0, 1, 0, 32'h300, 0);
        cycle(0, 0, 1, 0, 0);
        check("lifo.first", pop_data_r, 32'h300);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
        check("lifo.last", pop_data_r, 32'h100);
        cycle(0, 0, 0, 0, 0);

        // Nine pushes: reject keeps 0x10..0x17, wrap keeps 0x11..0x18.
        for (int i = 0; i < 9; i++) cycle(0, 1, 0, 32'h10 + i, 0);
        check("ovf.wrap_flag", overflow_w, 1'b1);
        check("ovf.rej_top", top_r, 32'h17);
        check("ovf.wrap_top", top_w, 32'h18);
        for (int i = 0; i < 9; i++) cycle(0, 0, 1, 0, 0);
        check("wrap.ninth_pop_unf", underflow_w, 1'b1);
        cycle(0, 0, 0, 0, 1);

        // Replace-top and empty bypass.
        cycle(0, 1, 0, 32'hA0, 0);
        cycle(0, 1, 1, 32'hB0, 0);
        check("replace.top", top_r, 32'hB0);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 1, 1, 32'hC0, 0);
        check("bypass.pop_data", pop_data_r, 32'hC0);

        // Underflow set vs clear priority.
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 1, 0, 1);
        check("unf.set_wins", underflow_r, 1'b1);
        cycle(0, 0, 0, 0, 1);

        // Reset discards a concurrent pop.
        cycle(0, 1, 0, 32'h40, 0);
        cycle(0, 1, 0, 32'h50, 0);
        cycle(1, 0, 1, 0, 0);
        check("reset.count", count_r, 0);
        cycle(0, 0, 0, 0, 0);

        // Random traffic biased toward filling and draining.
        for (int i = 0; i < 1500; i++) begin
            int phase = (i / 100) % 3;
            bit pu = ($urandom_range(0, 99) < (phase == 0 ? 70 : (phase == 1 ? 30 : 50)));
            bit po = ($urandom_range(0, 99) < (phase == 0 ? 25 : (phase == 1 ? 70 : 50)));
            bit rs = ($urandom_range(0, 299) == 0);
            bit clr = ($urandom_range(0, 19) == 0);
            cycle(rs, pu, po, $urandom, clr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
